// File: rtl/terrain_gen.sv
// Procedural terrain writer: seeded LFSR random walk producing one ground
// bitmap per screen column, streamed onto the terrain RAM write port.
//
//   state | meaning
//   IDLE  | waiting for start; registers hold last run (or reset) values
//   RUN   | owns the write port, one column written per clock
//   DONE  | one-cycle completion pulse, then back to IDLE
module terrain_gen #(
  parameter int COLS    = 640,
  parameter int ROWS    = 480,
  parameter int MIN_H   = 60,
  parameter int MAX_H   = 300,
  parameter int STEP    = 3,
  parameter int START_H = 180
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [9:0]      seed_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            we_o,
  output logic [9:0]      write_addr_o,
  output logic [ROWS-1:0] terrain_in_o,
  output logic [9:0]      height_out_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [9:0]        LAST_COL = 10'(COLS - 1);
  localparam logic signed [10:0] MIN_S   = 11'(MIN_H);
  localparam logic signed [10:0] MAX_S   = 11'(MAX_H);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);

  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [9:0]  height_q, height_d;
  logic [9:0]  col_q, col_d;

  logic signed [10:0] delta;
  logic signed [10:0] sum;
  logic               lfsr_fb;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE so runs cannot be restarted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (col_q == LAST_COL) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walk step: delta from the two LSBs before the shift, signed sum so a
  // downward step near zero cannot wrap before the clamp
  always_comb begin
    case (lfsr_q[1:0])
      2'b00:   delta = -STEP_S;
      2'b11:   delta = STEP_S;
      default: delta = '0;
    endcase
    sum     = $signed({1'b0, height_q}) + delta;
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  // Datapath next values: load on accepted start, advance on every RUN edge
  always_comb begin
    lfsr_d   = lfsr_q;
    height_d = height_q;
    col_d    = col_q;
    if (state_q == IDLE && start_i) begin
      lfsr_d   = {seed_i, 6'b100101};
      height_d = 10'(START_H);
      col_d    = '0;
    end else if (state_q == RUN) begin
      col_d  = col_q + 10'd1;
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
      if (sum < MIN_S)      height_d = 10'(MIN_H);
      else if (sum > MAX_S) height_d = 10'(MAX_H);
      else                  height_d = sum[9:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q   <= '0;
      height_q <= '0;
      col_q    <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      height_q <= height_d;
      col_q    <= col_d;
    end
  end

  // Outputs decoded from registers; bitmap bit r is ground when r >= ROWS-height
  always_comb begin
    busy_o       = (state_q == RUN);
    we_o         = (state_q == RUN);
    done_o       = (state_q == DONE);
    write_addr_o = col_q;
    height_out_o = height_q;
    for (int r = 0; r < ROWS; r++) begin
      terrain_in_o[r] = ((r + int'(height_q)) >= ROWS);
    end
  end

endmodule
